// File: rtl/disposition_dispatch_if.sv
// Handshake and bus bundle of the disposition stage: pipeline-tail input,
// context-cache record, per-channel read requests, write request and stall counter.
interface disposition_dispatch_if #(
    parameter int ID_W     = 16,
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int CTL_W    = 160,
    parameter int NUM_READ = 2,
    parameter int CNT_W    = 32
) ();
    logic                       in_valid;
    logic                       in_ready;
    logic [ID_W-1:0]            in_id;
    logic [CTL_W-1:0]           in_ctl;
    logic [NUM_READ-1:0]        in_rd_en;
    logic [NUM_READ*ID_W-1:0]   in_rd_recv_id;
    logic [NUM_READ*ADDR_W-1:0] in_rd_addr;
    logic                       in_wr_en;
    logic                       in_wr_back;
    logic [ADDR_W-1:0]          in_wr_addr;
    logic [ADDR_W-1:0]          in_data_address;
    logic [DATA_W-1:0]          in_wr_data;

    logic                       ctl_valid;
    logic [ID_W-1:0]            ctl_id;
    logic [CTL_W-1:0]           ctl;

    logic [NUM_READ-1:0]        rd_valid;
    logic [NUM_READ-1:0]        rd_ready;
    logic [NUM_READ*ID_W-1:0]   rd_req_id;
    logic [NUM_READ*ID_W-1:0]   rd_recv_id;
    logic [NUM_READ*ADDR_W-1:0] rd_addr;

    logic                       wr_valid;
    logic                       wr_ready;
    logic [ID_W-1:0]            wr_req_id;
    logic [ADDR_W-1:0]          wr_addr;
    logic [DATA_W-1:0]          wr_data;

    logic [CNT_W-1:0]           stall_cnt;

    modport master (
        input  in_valid, in_id, in_ctl, in_rd_en, in_rd_recv_id, in_rd_addr,
               in_wr_en, in_wr_back, in_wr_addr, in_data_address, in_wr_data,
               rd_ready, wr_ready,
        output in_ready, ctl_valid, ctl_id, ctl,
               rd_valid, rd_req_id, rd_recv_id, rd_addr,
               wr_valid, wr_req_id, wr_addr, wr_data, stall_cnt
    );

    modport slave (
        output in_valid, in_id, in_ctl, in_rd_en, in_rd_recv_id, in_rd_addr,
               in_wr_en, in_wr_back, in_wr_addr, in_data_address, in_wr_data,
               rd_ready, wr_ready,
        input  in_ready, ctl_valid, ctl_id, ctl,
               rd_valid, rd_req_id, rd_recv_id, rd_addr,
               wr_valid, wr_req_id, wr_addr, wr_data, stall_cnt
    );
endinterface

// File: rtl/disposition_dispatch.sv
// Disposition stage: one-cycle control record to the context cache plus
// per-channel read FIFOs and a write FIFO with valid/ready toward the data side.
module disposition_dispatch #(
    parameter int ID_W     = 16,
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int CTL_W    = 160,
    parameter int NUM_READ = 2,
    parameter int DEPTH    = 4,
    parameter int SELF_CH0 = 1,
    parameter int CNT_W    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    disposition_dispatch_if.master bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FCNT_W = PTR_W + 1;
    localparam logic [FCNT_W-1:0] FULL_CNT = FCNT_W'(DEPTH);

    typedef struct packed {
        logic [ID_W-1:0]   req_id;
        logic [ID_W-1:0]   recv_id;
        logic [ADDR_W-1:0] addr;
    } rd_entry_t;

    typedef struct packed {
        logic [ID_W-1:0]   req_id;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    rd_entry_t         rd_mem_q [NUM_READ][DEPTH];
    rd_entry_t         rd_mem_d [NUM_READ][DEPTH];
    logic [PTR_W-1:0]  rd_wp_q [NUM_READ], rd_wp_d [NUM_READ];
    logic [PTR_W-1:0]  rd_rp_q [NUM_READ], rd_rp_d [NUM_READ];
    logic [FCNT_W-1:0] rd_cnt_q [NUM_READ], rd_cnt_d [NUM_READ];
    wr_entry_t         wr_mem_q [DEPTH], wr_mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_wp_q, wr_wp_d, wr_rp_q, wr_rp_d;
    logic [FCNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic              run_q, run_d;
    logic              ctl_valid_q, ctl_valid_d;
    logic [ID_W-1:0]   ctl_id_q, ctl_id_d;
    logic [CTL_W-1:0]  ctl_q, ctl_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic                not_full_s, in_ready_s, accept_s;
    logic [NUM_READ-1:0] rd_push_s, rd_pop_s, rd_valid_s;
    logic                wr_push_s, wr_pop_s, wr_valid_s;
    rd_entry_t           rd_new_s [NUM_READ];
    wr_entry_t           wr_new_s;

    // Handshake: readiness looks only at registered counts, never at this cycle's pops
    always_comb begin
        not_full_s = (wr_cnt_q < FULL_CNT);
        for (int i = 0; i < NUM_READ; i++) begin
            not_full_s = not_full_s & (rd_cnt_q[i] < FULL_CNT);
        end
        in_ready_s = rst & run_q & not_full_s;
        accept_s   = bus.in_valid & in_ready_s;
        for (int i = 0; i < NUM_READ; i++) begin
            rd_new_s[i].req_id  = bus.in_id;
            rd_new_s[i].recv_id = ((SELF_CH0 != 0) && (i == 0)) ? bus.in_id
                                                                  : bus.in_rd_recv_id[i*ID_W +: ID_W];
            rd_new_s[i].addr    = bus.in_rd_addr[i*ADDR_W +: ADDR_W];
            rd_push_s[i]  = accept_s & bus.in_rd_en[i];
            rd_valid_s[i] = rst & (rd_cnt_q[i] != '0);
            rd_pop_s[i]   = rd_valid_s[i] & bus.rd_ready[i];
        end
        wr_new_s.req_id = bus.in_id;
        wr_new_s.addr   = bus.in_wr_back ? bus.in_data_address : bus.in_wr_addr;
        wr_new_s.data   = bus.in_wr_data;
        wr_push_s  = accept_s & bus.in_wr_en;
        wr_valid_s = rst & (wr_cnt_q != '0);
        wr_pop_s   = wr_valid_s & bus.wr_ready;
    end

    // Next state: FIFO pointers/counts, stored entries, control record, stall counter
    always_comb begin
        rd_mem_d = rd_mem_q;
        wr_mem_d = wr_mem_q;
        for (int i = 0; i < NUM_READ; i++) begin
            rd_wp_d[i]  = rd_wp_q[i] + PTR_W'(rd_push_s[i]);
            rd_rp_d[i]  = rd_rp_q[i] + PTR_W'(rd_pop_s[i]);
            rd_cnt_d[i] = rd_cnt_q[i] + FCNT_W'(rd_push_s[i]) - FCNT_W'(rd_pop_s[i]);
            if (rd_push_s[i]) begin
                rd_mem_d[i][rd_wp_q[i]] = rd_new_s[i];
            end else begin
                rd_mem_d[i][rd_wp_q[i]] = rd_mem_q[i][rd_wp_q[i]];
            end
        end
        wr_wp_d  = wr_wp_q + PTR_W'(wr_push_s);
        wr_rp_d  = wr_rp_q + PTR_W'(wr_pop_s);
        wr_cnt_d = wr_cnt_q + FCNT_W'(wr_push_s) - FCNT_W'(wr_pop_s);
        if (wr_push_s) begin
            wr_mem_d[wr_wp_q] = wr_new_s;
        end else begin
            wr_mem_d[wr_wp_q] = wr_mem_q[wr_wp_q];
        end
        run_d       = 1'b1;
        ctl_valid_d = accept_s;
        ctl_id_d    = accept_s ? bus.in_id : '0;
        ctl_d       = accept_s ? bus.in_ctl : '0;
        if (bus.in_valid && !in_ready_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1'b1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers with synchronous active-low reset that flushes all queues
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_READ; i++) begin
                rd_wp_q[i]  <= '0;
                rd_rp_q[i]  <= '0;
                rd_cnt_q[i] <= '0;
                for (int j = 0; j < DEPTH; j++) begin
                    rd_mem_q[i][j] <= '0;
                end
            end
            for (int j = 0; j < DEPTH; j++) begin
                wr_mem_q[j] <= '0;
            end
            wr_wp_q     <= '0;
            wr_rp_q     <= '0;
            wr_cnt_q    <= '0;
            run_q       <= 1'b0;
            ctl_valid_q <= 1'b0;
            ctl_id_q    <= '0;
            ctl_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            rd_mem_q    <= rd_mem_d;
            rd_wp_q     <= rd_wp_d;
            rd_rp_q     <= rd_rp_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_mem_q    <= wr_mem_d;
            wr_wp_q     <= wr_wp_d;
            wr_rp_q     <= wr_rp_d;
            wr_cnt_q    <= wr_cnt_d;
            run_q       <= run_d;
            ctl_valid_q <= ctl_valid_d;
            ctl_id_q    <= ctl_id_d;
            ctl_q       <= ctl_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Outputs: FIFO heads are presented only while non-empty, zero otherwise
    always_comb begin
        bus.in_ready   = in_ready_s;
        bus.ctl_valid  = ctl_valid_q;
        bus.ctl_id     = ctl_id_q;
        bus.ctl        = ctl_q;
        bus.stall_cnt  = stall_cnt_q;
        bus.rd_valid   = rd_valid_s;
        bus.rd_req_id  = '0;
        bus.rd_recv_id = '0;
        bus.rd_addr    = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            if (rd_valid_s[i]) begin
                bus.rd_req_id[i*ID_W +: ID_W]    = rd_mem_q[i][rd_rp_q[i]].req_id;
                bus.rd_recv_id[i*ID_W +: ID_W]   = rd_mem_q[i][rd_rp_q[i]].recv_id;
                bus.rd_addr[i*ADDR_W +: ADDR_W]  = rd_mem_q[i][rd_rp_q[i]].addr;
            end else begin
                bus.rd_req_id[i*ID_W +: ID_W]    = '0;
                bus.rd_recv_id[i*ID_W +: ID_W]   = '0;
                bus.rd_addr[i*ADDR_W +: ADDR_W]  = '0;
            end
        end
        bus.wr_valid = wr_valid_s;
        if (wr_valid_s) begin
            bus.wr_req_id = wr_mem_q[wr_rp_q].req_id;
            bus.wr_addr   = wr_mem_q[wr_rp_q].addr;
            bus.wr_data   = wr_mem_q[wr_rp_q].data;
        end else begin
            bus.wr_req_id = '0;
            bus.wr_addr   = '0;
            bus.wr_data   = '0;
        end
    end
endmodule

// File: doc/disposition_dispatch.md
# disposition_dispatch

Parametrised disposition stage with backpressure. It accepts one retired-thread result per cycle from the pipeline tail and emits a one-cycle control record to the context cache. It queues up to `NUM_READ` read requests and one write request into per-channel FIFOs, each with valid/ready handshakes to the data interface. It replaces the fixed two-read, no-backpressure disposition stage, so that memory stalls no longer drop requests.

## Interface
Parameters:
- `ID_W`, 16: thread id width.
- `ADDR_W`, 64: address width.
- `DATA_W`, 64: write data width.
- `CTL_W`, 160: opaque cache-control bundle width (delete, sleep, exec, fork fields).
- `NUM_READ`, 2: read channels; legal range 1..8.
- `DEPTH`, 4: entries per FIFO; power of two, ≥2.
- `SELF_CH0`, 1: when 1, channel 0 receive id is forced to `in_id`.
- `CNT_W`, 32: stall counter width.

Ports (name, direction, width, meaning):
- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-low.
- `in_valid` in 1, `in_ready` out 1: input handshake.
- `in_id` in ID_W: issuing thread id.
- `in_ctl` in CTL_W: pre-evaluated cache-control bundle.
- `in_rd_en` in NUM_READ: per-channel read request, condition already evaluated.
- `in_rd_recv_id` in NUM_READ*ID_W: per-channel receiver id, packed with channel 0 in the LSBs.
- `in_rd_addr` in NUM_READ*ADDR_W: per-channel read address, packed.
- `in_wr_en` in 1, `in_wr_back` in 1: write request; write-back select.
- `in_wr_addr` in ADDR_W, `in_data_address` in ADDR_W, `in_wr_data` in DATA_W.
- `ctl_valid` out 1, `ctl_id` out ID_W, `ctl` out CTL_W: cache record. No backpressure.
- `rd_valid` out NUM_READ, `rd_ready` in NUM_READ: per-channel read handshake.
- `rd_req_id` out NUM_READ*ID_W, `rd_recv_id` out NUM_READ*ID_W, `rd_addr` out NUM_READ*ADDR_W.
- `wr_valid` out 1, `wr_ready` in 1, `wr_req_id` out ID_W, `wr_addr` out ADDR_W, `wr_data` out DATA_W.
- `stall_cnt` out CNT_W: count of cycles with `in_valid` high and `in_ready` low.

## Operation
- Accept happens when `in_valid && in_ready`.
- `in_ready` is high only when every FIFO (all read channels plus the write FIFO) holds fewer than `DEPTH` entries.
  - It is computed from registered counts only.
  - It does not depend on `in_valid`, `in_rd_en`, or a same-cycle pop.
- On accept:
  - The control record is registered: `ctl_id` = `in_id`, `ctl` = `in_ctl`.
  - Each read channel with `in_rd_en[i]` set pushes {req_id = `in_id`, recv_id, addr}.
    - recv_id is `in_id` for channel 0 when `SELF_CH0` = 1; otherwise it is the packed field.
  - If `in_wr_en` is set, the write FIFO pushes {req_id = `in_id`, addr, data}.
    - addr = `in_wr_back` ? `in_data_address` : `in_wr_addr`.
- Channels whose enable is clear push nothing.
- With no accept, `ctl_valid` is 0 and `ctl_id`/`ctl` are 0.
- FIFOs:
  - Circular buffer with log2(DEPTH)-bit pointers that wrap modulo DEPTH.
  - Count is log2(DEPTH)+1 bits.
  - Head entry drives the outputs while non-empty; `*_valid` = non-empty.
  - Pop happens on `valid && ready`.
  - Simultaneous push and pop leaves the count unchanged and both pointers advance.
  - Pop on empty is ignored; outputs stay 0 while empty.
- Requests from one accepted input issue independently per channel. There is no cross-channel ordering. Ordering within a channel is FIFO.
- `stall_cnt` increments by 1 per stall cycle and saturates at 2^CNT_W−1.
- Reset (`rst` = 0, sampled at a `clk` edge):
  - FIFOs are emptied, pointers zeroed, `stall_cnt` = 0.
  - `ctl_valid`, `ctl_id`, `ctl` = 0.
  - All `rd_valid`, `wr_valid` and data outputs = 0.
  - `in_ready` = 0 while `rst` = 0.
  - Reset mid-operation discards queued requests; no request is emitted after reset asserts.

## Timing
- Control path latency is 1: accept at edge N gives `ctl_valid` = 1 for exactly the cycle after edge N.
- Request latency: a push at edge N into an empty FIFO gives valid from edge N onward, i.e. visible in cycle N+1. A push into a non-empty FIFO waits behind older entries.
- Throughput: one accept per cycle while every FIFO is below full.
- Full boundary:
  - After DEPTH accepts with `rd_ready[i]` = 0, `in_ready` drops in the following cycle.
  - A pop at edge M restores `in_ready` in cycle M+1. There is no same-cycle bypass.
- `in_ready` rises in the cycle after `rst` returns to 1.

## Test plan
- Reset with `rst` = 0 for 3 cycles: all outputs read 0 and `stall_cnt` = 0. Release: `in_ready` = 1 the next cycle.
- Single accept with id 0x42, `in_rd_en` = 2'b11, recv_id[1] = 7, addr0 = 0x100, addr1 = 0x200, write back with `in_data_address` = 0x300, all ready high:
  - Next cycle: `ctl_valid` = 1 with `ctl_id` = 0x42.
  - rd0 carries {0x42, 0x42, 0x100}; rd1 carries {0x42, 7, 0x200}; wr carries addr 0x300.
  - Every request is popped in that same cycle.
- Hold `rd_ready[1]` = 0 with DEPTH = 4 and send 6 back-to-back inputs, all enabled:
  - `in_ready` falls after the 4th accept and `stall_cnt` advances by 1 per blocked cycle.
  - Releasing `rd_ready[1]` drains ids in order.
- Run wrap-around for 3×DEPTH inputs with random ready: every channel outputs ids in accept order with no loss or duplication.
- Enables all 0 for 5 accepts: five `ctl_valid` pulses, no `rd_valid`/`wr_valid`, FIFO counts stay 0.
- Assert reset with 3 entries queued: next cycle all valids are 0. After release, no stale request appears.
